// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO controller.
//   REG_*      : 3-bit word indices of the register map (byte offset >> 2)
//   access_t   : decoded bus access for the current cycle
//   decode()   : turns raw Wishbone strobes into a single-shot access
//   byte_mask(): expands byte enables into a 32-bit bit mask
package wb_gpio_pkg;

  localparam logic [2:0] REG_DOUT     = 3'd0;
  localparam logic [2:0] REG_DIN      = 3'd1;
  localparam logic [2:0] REG_OE       = 3'd2;
  localparam logic [2:0] REG_SET      = 3'd3;
  localparam logic [2:0] REG_CLR      = 3'd4;
  localparam logic [2:0] REG_RISE_EN  = 3'd5;
  localparam logic [2:0] REG_FALL_EN  = 3'd6;
  localparam logic [2:0] REG_IRQ_STAT = 3'd7;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [2:0] idx;
  } access_t;

  // An access is accepted only in the cycle before ack, so a strobe held
  // high across several cycles is serviced once per ack, never twice.
  function automatic access_t decode(input logic       valid,
                                     input logic       ack,
                                     input logic       we,
                                     input logic [2:0] word);
    access_t a;
    a.wr  = valid & ~ack & we;
    a.rd  = valid & ~ack & ~we;
    a.idx = word;
    return a;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{sel[k]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic slave bus bundle for wb_gpio_irq.
// Handshake: a request is valid while wb_cyc_i & wb_stb_i are both high;
// the slave answers with a single-cycle wb_ack_o one cycle later and the
// master must keep the request stable until it samples ack. wb_dat_o is
// meaningful only while wb_ack_o is high and reads 0 otherwise.
//   master modport: drives adr/dat_i/sel/we/stb/cyc, samples dat_o/ack
//   slave  modport: the reverse
interface wb_gpio_irq_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// Input synchroniser and edge detector for W asynchronous pins.
//   pin  : raw asynchronous inputs
//   din  : synchronised value (last stage of an STAGES-deep chain)
//   rise : din went 0->1 this cycle (one cycle wide)
//   fall : din went 1->0 this cycle (one cycle wide)
module gpio_sync_edge #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pin,
  output logic [W-1:0] din,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign din  = sync_q[STAGES-1];
  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO controller with per-pin edge interrupts.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : Wishbone slave (wb_gpio_irq_if.slave), one wait state
//   gpio_in    : asynchronous pin inputs
//   gpio_out   : DOUT register
//   gpio_oe    : OE register (1 = drive)
//   irq_o      : registered OR of IRQ_STAT
// Register bits at and above NGPIO read 0 and ignore writes.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int               NGPIO       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NGPIO-1:0] DOUT_RST    = '0,
  parameter logic [NGPIO-1:0] OE_RST      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_gpio_irq_if.slave     bus,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             irq_o
);

  access_t          acc;
  logic [31:0]      wmask;
  logic [31:0]      rdata;
  logic [NGPIO-1:0] wen, wbits, w1c;
  logic [NGPIO-1:0] din, rise, fall;
  logic [NGPIO-1:0] dout_q, oe_q, rise_en_q, fall_en_q, stat_q;
  logic             unused_bits;

  gpio_sync_edge #(.W(NGPIO), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (gpio_in),
    .din   (din),
    .rise  (rise),
    .fall  (fall)
  );

  assign acc   = decode(bus.wb_cyc_i & bus.wb_stb_i, bus.wb_ack_o,
                        bus.wb_we_i, bus.wb_adr_i[4:2]);
  assign wmask = byte_mask(bus.wb_sel_i);
  assign wen   = wmask[NGPIO-1:0];
  // Byte-enabled data bits: the bits SET/CLR/W1C act on.
  assign wbits = bus.wb_dat_i[NGPIO-1:0] & wen;
  assign w1c   = (acc.wr && acc.idx == REG_IRQ_STAT) ? wbits : '0;

  // Address bits outside [4:2] alias; upper data/mask bits are dropped.
  assign unused_bits = ^{bus.wb_adr_i[31:5], bus.wb_adr_i[1:0],
                         bus.wb_dat_i, wmask};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= DOUT_RST;
      oe_q      <= OE_RST;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (acc.wr) begin
      case (acc.idx)
        REG_DOUT:    dout_q    <= (dout_q & ~wen) | wbits;
        REG_OE:      oe_q      <= (oe_q & ~wen) | wbits;
        REG_SET:     dout_q    <= dout_q | wbits;
        REG_CLR:     dout_q    <= dout_q & ~wbits;
        REG_RISE_EN: rise_en_q <= (rise_en_q & ~wen) | wbits;
        REG_FALL_EN: fall_en_q <= (fall_en_q & ~wen) | wbits;
        default:     ;
      endcase
    end
  end

  // A new edge event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      stat_q <= (stat_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
      irq_o  <= |stat_q;
    end
  end

  always_comb begin
    rdata = '0;
    case (acc.idx)
      REG_DOUT:     rdata[NGPIO-1:0] = dout_q;
      REG_DIN:      rdata[NGPIO-1:0] = din;
      REG_OE:       rdata[NGPIO-1:0] = oe_q;
      REG_RISE_EN:  rdata[NGPIO-1:0] = rise_en_q;
      REG_FALL_EN:  rdata[NGPIO-1:0] = fall_en_q;
      REG_IRQ_STAT: rdata[NGPIO-1:0] = stat_q;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= '0;
    end else begin
      bus.wb_ack_o <= acc.wr | acc.rd;
      bus.wb_dat_o <= acc.rd ? rdata : '0;
    end
  end

  assign gpio_out = dout_q;
  assign gpio_oe  = oe_q;

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
Parametrised Wishbone-slave GPIO controller and successor to the single-register GPIO wrapper. It provides NGPIO pins with per-pin output enable, atomic set/clear writes, and synchronised inputs. Per-pin rising and falling edge detection feeds a sticky, write-1-to-clear interrupt status. It sits on the system Wishbone bus beside the other peripherals and drives one level interrupt line to the CPU.

Parameters:
NGPIO, 32, number of pins (1..32); register bits at and above NGPIO read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth (>=2)
DOUT_RST, 0, reset value of DOUT (NGPIO bits)
OE_RST, 0, reset value of OE (NGPIO bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wb_adr_i  in  32  byte address; only bits [4:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, valid while wb_ack_o=1, else 0
wb_sel_i  in  4  byte enables for writes
wb_we_i  in  1  write strobe
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  single-cycle acknowledge
gpio_in  in  NGPIO  asynchronous pin inputs
gpio_out  out  NGPIO  DOUT register
gpio_oe  out  NGPIO  OE register (1 = drive)
irq_o  out  1  |(IRQ_STAT), registered

Behaviour:
- Reset (rst_n=0, async): wb_ack_o=0, wb_dat_o=0, DOUT=DOUT_RST, OE=OE_RST, RISE_EN=FALL_EN=IRQ_STAT=0, synchroniser and edge flops=0, irq_o=0.
- Register map (offset, access): 0x00 DOUT rw; 0x04 DIN ro (synchronised pins); 0x08 OE rw; 0x0C SET wo (DOUT|=data); 0x10 CLR wo (DOUT&=~data); 0x14 RISE_EN rw; 0x18 FALL_EN rw; 0x1C IRQ_STAT rw1c. SET and CLR read 0.
- Handshake: valid=wb_cyc_i&wb_stb_i. wb_ack_o <= valid & ~wb_ack_o. This gives one wait state per access: ack in the cycle after valid, then ack deasserts for one cycle, even with stb held. Back-to-back accesses complete every 2 cycles.
- A write takes effect on the same edge that raises ack; it is gated by valid & ~wb_ack_o & wb_we_i, so each access writes exactly once. wb_sel_i[k] gates bits [8k+7:8k] for DOUT/OE/RISE_EN/FALL_EN and gates which bits of SET/CLR/W1C act.
- Reads: wb_dat_o is registered on the same edge as ack and returns to 0 the following cycle. Unmapped addresses never occur (3-bit decode covers all). Upper address bits are ignored (aliasing).
- Input path: SYNC_STAGES flop chain per pin; DIN = last stage. A pin change is visible in DIN SYNC_STAGES cycles later. A prev flop holds DIN from the previous cycle. rise=DIN&~prev, fall=~DIN&prev, each one cycle wide.
- IRQ_STAT[i] <= (IRQ_STAT[i] & ~w1c[i]) | (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]). A new event and a W1C of the same bit in the same cycle: set wins. Disabling an enable does not clear existing status.
- irq_o registered from |IRQ_STAT, so it lags status by 1 cycle.
- Reset mid-transaction: ack drops immediately and the pending access is lost. The master must restart it.

Decomposition:
- Package wb_gpio_pkg: register offset constants (REG_DOUT..REG_IRQ_STAT as 3-bit word indices) and the access-decode helper function.
- Sub-module gpio_sync_edge (params W, STAGES): synchroniser chain, prev flop, rise/fall outputs. It is instantiated once with W=NGPIO. The top module holds bus decode, registers, status and irq.

Test Plan:
- Reset then read all 8 offsets -> DOUT=DOUT_RST, OE=OE_RST, others 0, irq_o=0; each ack exactly 1 cycle, 1 cycle after stb.
- Write DOUT=0xA5A5_0000 sel=4'b1100, then SET 0x0000_00FF, then CLR 0x0500_0000 -> gpio_out=0xA0A5_00FF, DOUT read matches.
- Hold stb/cyc high for 6 cycles with write to OE=0x1 -> ack pattern 0,1,0,1,0,1; OE=0x1; no extra side effects.
- RISE_EN=0x1; gpio_in[0] 0->1 at cycle t -> DIN[0]=1 at t+2, IRQ_STAT=0x1 at t+3, irq_o=1 at t+4; write IRQ_STAT=0x1 -> irq_o falls 1 cycle after status clears.
- FALL_EN=0x2, pulse gpio_in[1] low for 5 cycles while writing W1C bit1 in the event cycle -> IRQ_STAT[1] stays 1 (set wins).
- NGPIO=8 build: write DOUT=0xFFFF_FFFF -> readback 0x0000_00FF; assert rst_n mid-read -> ack=0 and wb_dat_o=0 immediately.
